// File: rtl/spi_master_if.sv
// spi_master_if -- bundles the control-side handshake and the SPI pins of
// spi_master.
//   start    : frame request from the control logic
//   tx_data  : 16-bit word to send
//   miso     : serial data from the slave
//   sclk     : SPI clock, idle low
//   mosi     : serial data to the slave
//   SS       : active-low slave select
//   busy     : frame in progress
//   done     : one-cycle completion pulse
//   rx_data  : captured MISO word
// modport master : the spi_master side
// modport slave  : the control logic / pin side that drives start, tx_data, miso
interface spi_master_if;
   logic        start;
   logic [15:0] tx_data;
   logic        miso;
   logic        sclk;
   logic        mosi;
   logic        SS;
   logic        busy;
   logic        done;
   logic [15:0] rx_data;

   modport master (
      input  start, tx_data, miso,
      output sclk, mosi, SS, busy, done, rx_data
   );

   modport slave (
      output start, tx_data, miso,
      input  sclk, mosi, SS, busy, done, rx_data
   );
endinterface

// File: rtl/spi_master.sv
// spi_master -- sends one 16-bit word per frame as two SPI mode-0 bytes,
// MSB first, each byte framed by its own SS low window, and captures MISO
// into a 16-bit receive word.
//   clk      : system clock
//   reset    : asynchronous, active-high reset
//   bus      : spi_master_if.master (start/tx_data/miso in,
//              sclk/mosi/SS/busy/done/rx_data out, all outputs registered)
//   HALF_DIV : clk cycles per SCLK half period, legal 4..255
module spi_master #(
   parameter int unsigned HALF_DIV = 8
) (
   input logic           clk,
   input logic           reset,
   spi_master_if.master  bus
);

   typedef enum logic [2:0] {IDLE, LOW, HIGH, GAP, TAIL} state_e;

   localparam logic [7:0] H_LAST = 8'(HALF_DIV - 1);

   state_e      state_q, state_d;
   logic [7:0]  hcnt_q, hcnt_d;
   logic [2:0]  bit_q, bit_d;
   logic        byte_q, byte_d;
   logic [15:0] tx_q, tx_d;
   logic [15:0] rx_q, rx_d;
   logic        miso_s1_q, miso_s2_q;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        ss_q, ss_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] rx_data_q, rx_data_d;

   logic half_end;
   assign half_end = (hcnt_q == H_LAST);

   // state register and all datapath flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         hcnt_q    <= '0;
         bit_q     <= '0;
         byte_q    <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         miso_s1_q <= 1'b0;
         miso_s2_q <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         ss_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         miso_s1_q <= bus.miso;
         miso_s2_q <= miso_s1_q;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ss_q      <= ss_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.start) state_d = LOW;
         LOW:  if (half_end) state_d = HIGH;
         HIGH: if (half_end) begin
                  if (bit_q != 3'd7) state_d = LOW;
                  else if (!byte_q)  state_d = GAP;
                  else               state_d = TAIL;
               end
         // GAP/TAIL last two half periods; bit_q[0] marks the second half
         GAP:  if (half_end && bit_q[0]) state_d = LOW;
         TAIL: if (half_end && bit_q[0]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // output and datapath logic
   always_comb begin
      hcnt_d    = (state_q == IDLE || half_end) ? 8'd0 : hcnt_q + 8'd1;
      bit_d     = bit_q;
      byte_d    = byte_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      ss_d      = ss_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rx_data_d = rx_data_q;
      case (state_q)
         IDLE: if (bus.start) begin
                  tx_d   = bus.tx_data;
                  ss_d   = 1'b0;
                  mosi_d = bus.tx_data[15];
                  busy_d = 1'b1;
                  byte_d = 1'b0;
                  bit_d  = 3'd0;
               end
         LOW:  if (half_end) sclk_d = 1'b1;
         HIGH: if (half_end) begin
                  sclk_d = 1'b0;
                  rx_d   = {rx_q[14:0], miso_s2_q};
                  tx_d   = {tx_q[14:0], 1'b0};
                  bit_d  = bit_q + 3'd1;   // wraps to 0 after bit 7
                  if (bit_q != 3'd7) begin
                     mosi_d = tx_q[14];    // next bit before the shift lands
                  end else begin
                     ss_d   = 1'b1;
                     mosi_d = 1'b0;
                  end
               end
         GAP:  if (half_end) begin
                  if (bit_q[0]) begin
                     bit_d  = 3'd0;
                     ss_d   = 1'b0;
                     mosi_d = tx_q[15];    // original tx_data[7] after 8 shifts
                     byte_d = 1'b1;
                  end else begin
                     bit_d = 3'd1;
                  end
               end
         TAIL: if (half_end) begin
                  if (bit_q[0]) begin
                     bit_d     = 3'd0;
                     done_d    = 1'b1;
                     busy_d    = 1'b0;
                     rx_data_d = rx_q;
                  end else begin
                     bit_d = 3'd1;
                  end
               end
         default: ;
      endcase
   end

   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.SS      = ss_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- directed bench for spi_master with HALF_DIV=4: pin
// timing, loopback capture, start/tx_data ignored while busy, reset abort,
// and back-to-back frames seen by a behavioural byte collector.
module tb_spi_master;
   localparam int H = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic loop = 1'b0;
   always #5 clk = ~clk;

   spi_master_if bus_if();
   assign bus_if.miso = loop ? bus_if.mosi : 1'b0;

   spi_master #(.HALF_DIV(H)) dut (.clk(clk), .reset(reset), .bus(bus_if));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor / collector ----------------
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        mon_clr = 1'b0;
   logic        prev_sclk = 1'b0, prev_ss = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;
   int          low_cnt = 0, high_cnt = 0;
   int          win_a [8];
   int          gap_a [8];
   int          win_n = 0, gap_n = 0;
   logic [15:0] word_a [4];
   int          word_n = 0;
   int          done_cnt = 0, done_wide = 0;
   int          t_acc = 0, t_done = 0;
   logic [15:0] rx_last = '0;
   logic [15:0] mosi_word = '0;
   int          mosi_n = 0;
   logic [7:0]  cbyte = '0, hi_byte = '0;
   int          cbits = 0;
   logic        have_hi = 1'b0;

   always @(negedge clk) begin
      if (mon_clr) begin
         low_cnt <= 0; high_cnt <= 0; win_n <= 0; gap_n <= 0; word_n <= 0;
         done_cnt <= 0; done_wide <= 0; mosi_word <= '0; mosi_n <= 0;
         cbits <= 0; have_hi <= 1'b0;
      end else begin
         if (bus_if.sclk && !prev_sclk && !bus_if.SS) begin
            mosi_word <= {mosi_word[14:0], bus_if.mosi};
            mosi_n    <= mosi_n + 1;
            cbyte     <= {cbyte[6:0], bus_if.mosi};
            cbits     <= cbits + 1;
         end
         if (!bus_if.SS) low_cnt <= low_cnt + 1;
         else            high_cnt <= high_cnt + 1;
         if (bus_if.SS && !prev_ss) begin
            if (win_n < 8) win_a[win_n] <= low_cnt;
            win_n   <= win_n + 1;
            low_cnt <= 0;
            if (cbits == 8) begin
               if (!have_hi) begin
                  hi_byte <= cbyte;
                  have_hi <= 1'b1;
               end else begin
                  if (word_n < 4) word_a[word_n] <= {hi_byte, cbyte};
                  word_n  <= word_n + 1;
                  have_hi <= 1'b0;
               end
            end
            cbits <= 0;
         end
         if (!bus_if.SS && prev_ss) begin
            if (gap_n < 8) gap_a[gap_n] <= high_cnt;
            gap_n    <= gap_n + 1;
            high_cnt <= 0;
         end
         if (bus_if.busy && !prev_busy) t_acc <= cyc;
         if (bus_if.done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
            rx_last  <= bus_if.rx_data;
            if (prev_done) done_wide <= done_wide + 1;
         end
      end
      prev_sclk <= bus_if.sclk;
      prev_ss   <= bus_if.SS;
      prev_busy <= bus_if.busy;
      prev_done <= bus_if.done;
   end

   // ---------------- stimulus helpers ----------------
   task automatic clr_mon();
      @(posedge clk); #1 mon_clr = 1'b1;
      @(posedge clk); #1 mon_clr = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic wait_done(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && done_cnt < n; i++) begin
         @(negedge clk); #1;
      end
      chk(tag, done_cnt, n);
   endtask

   task automatic send(input logic [15:0] w);
      @(negedge clk); #1;
      bus_if.tx_data = w;
      bus_if.start   = 1'b1;
      @(negedge clk); #1;
      bus_if.start   = 1'b0;
   endtask

   task automatic chk_idle_pins(input string tag);
      chk({tag, "_sclk"}, bus_if.sclk, 1'b0);
      chk({tag, "_mosi"}, bus_if.mosi, 1'b0);
      chk({tag, "_ss"},   bus_if.SS,   1'b1);
      chk({tag, "_busy"}, bus_if.busy, 1'b0);
      chk({tag, "_done"}, bus_if.done, 1'b0);
      chk({tag, "_rx"},   bus_if.rx_data, 16'h0000);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bus_if.start   = 1'b0;
      bus_if.tx_data = '0;
      #12;
      chk_idle_pins("por");
      @(negedge clk); reset = 1'b0;
      clr_mon();

      // basic frame: bit order, SS windows, latency
      send(16'hA55A);
      wait_done(1, 400, "a55a_done");
      chk("a55a_mosi_bits", mosi_word, 16'hA55A);
      chk("a55a_nbits", mosi_n, 16);
      chk("a55a_win0", win_a[0], 4 * 16);
      chk("a55a_win1", win_a[1], 4 * 16);
      chk("a55a_gap", gap_a[1], 8);
      chk("a55a_latency", t_done - t_acc, 144);
      chk("a55a_coll", word_a[0], 16'hA55A);
      chk("a55a_busy_after", bus_if.busy, 1'b0);

      // loopback capture
      clr_mon();
      loop = 1'b1;
      send(16'h3C81);
      wait_done(1, 400, "loop_done");
      chk("loop_rx", rx_last, 16'h3C81);
      chk("loop_rx_port", bus_if.rx_data, 16'h3C81);

      // start pulse and tx_data change during a frame are ignored
      clr_mon();
      send(16'h0F0F);
      cycles(20);
      bus_if.tx_data = 16'hFFFF;
      bus_if.start   = 1'b1;
      cycles(1);
      bus_if.start   = 1'b0;
      wait_done(1, 400, "ign_done");
      cycles(200);
      chk("ign_one_done", done_cnt, 1);
      chk("ign_rx", rx_last, 16'h0F0F);
      chk("ign_coll", word_a[0], 16'h0F0F);
      chk("ign_busy", bus_if.busy, 1'b0);

      // reset during byte 1 abandons the frame
      clr_mon();
      send(16'h1234);
      cycles(100);
      chk("abort_in_frame", bus_if.SS, 1'b0);
      reset = 1'b1;
      #1;
      chk_idle_pins("abort");
      cycles(3);
      reset = 1'b0;
      cycles(200);
      chk("abort_no_done", done_cnt, 0);
      clr_mon();
      send(16'h00FF);
      wait_done(1, 400, "after_abort_done");
      chk("after_abort_rx", rx_last, 16'h00FF);
      chk("after_abort_coll", word_a[0], 16'h00FF);

      // start held high: back-to-back frames
      clr_mon();
      loop = 1'b0;
      @(negedge clk); #1;
      bus_if.tx_data = 16'h1234;
      bus_if.start   = 1'b1;
      cycles(30);
      bus_if.tx_data = 16'hBEEF;
      wait_done(2, 600, "b2b_done");
      bus_if.start = 1'b0;
      cycles(300);
      chk("b2b_two_done", done_cnt, 2);
      chk("b2b_words", word_n, 2);
      chk("b2b_word0", word_a[0], 16'h1234);
      chk("b2b_word1", word_a[1], 16'hBEEF);
      chk("b2b_frame_gap", gap_a[2], 9);
      chk("b2b_done_wide", done_wide, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
